// File: rtl/udp_tx_sched_pkg.sv
// Shared definitions for the UDP transmit scheduler: FSM state encoding,
// datapath widths and the grant-index width helper.
package udp_tx_sched_pkg;

  localparam int BYTE_NUM_W = 16;
  localparam int DATA_W     = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    GAP   = 2'd3
  } state_t;

  // Bits needed to index num_ch channels (at least 1).
  function automatic int ch_w(input int num_ch);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < num_ch) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/udp_tx_sched_rr_pick.sv
// Combinational round-robin selector: returns the first pending channel
// found searching upward from last_grant+1, wrapping modulo NUM_CH.
module udp_tx_sched_rr_pick
  import udp_tx_sched_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int CH_W   = ch_w(NUM_CH)
) (
  input  logic [NUM_CH-1:0] pending,
  input  logic [CH_W-1:0]   last_grant,
  output logic              valid,
  output logic [CH_W-1:0]   index
);

  logic [CH_W-1:0] cand;

  // Walk from the farthest offset to the nearest so the closest pending channel is written last and wins.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int off = NUM_CH; off >= 1; off--) begin
      cand = CH_W'((int'(last_grant) + off) % NUM_CH);
      if (pending[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/udp_tx_sched.sv
// Round-robin scheduler sharing one UDP transmit engine between NUM_CH
// packet sources. Latches start pulses, grants one channel at a time,
// routes engine requests/data and returns the completion pulse.
// Optional BUSY watchdog enabled by defining UDP_TX_TIMEOUT_EN.
module udp_tx_sched
  import udp_tx_sched_pkg::*;
#(
  parameter int NUM_CH         = 2,
  parameter int GAP_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         eth_tx_clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            ch_start_en,
  input  logic [NUM_CH*BYTE_NUM_W-1:0] ch_byte_num,
  input  logic [NUM_CH*DATA_W-1:0]     ch_tx_data,
  output logic [NUM_CH-1:0]            ch_tx_req,
  output logic [NUM_CH-1:0]            ch_tx_done,
  output logic [NUM_CH-1:0]            ch_busy,
  output logic                         tx_start_en,
  output logic [BYTE_NUM_W-1:0]        tx_byte_num,
  output logic [DATA_W-1:0]            tx_data,
  input  logic                         tx_req,
  input  logic                         tx_done,
  output logic [ch_w(NUM_CH)-1:0]      grant_id,
  output logic                         timeout_flag
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam logic [CH_W-1:0] LAST_GRANT_RST = CH_W'(NUM_CH - 1);

  if (NUM_CH < 2 || NUM_CH > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_params
    $error("udp_tx_sched: NUM_CH must be 2..8 and TIMEOUT_CYCLES 1..65535");
  end

  state_t                state_reg, state_next;
  logic [NUM_CH-1:0]     pending_reg, pending_next;
  logic [CH_W-1:0]       grant_reg, grant_next;
  logic [CH_W-1:0]       last_grant_reg, last_grant_next;
  logic [BYTE_NUM_W-1:0] byte_num_reg, byte_num_next;
  logic                  done_pulse_reg, done_pulse_next;
  logic [15:0]           gap_cnt_reg, gap_cnt_next;

  logic                  pick_valid;
  logic [CH_W-1:0]       pick_index;
  logic                  done_now;
  logic                  timeout_hit;

  logic [BYTE_NUM_W-1:0] byte_num_arr [NUM_CH];
  logic [DATA_W-1:0]     data_arr [NUM_CH];

  udp_tx_sched_rr_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_rr_pick (
    .pending    (pending_reg),
    .last_grant (last_grant_reg),
    .valid      (pick_valid),
    .index      (pick_index)
  );

  // Completion is either a zero-length packet finishing in START or the registered echo of tx_done/abort.
  assign done_now = ((state_reg == START) && (byte_num_reg == '0)) || done_pulse_reg;

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    assign byte_num_arr[gi] = ch_byte_num[gi*BYTE_NUM_W +: BYTE_NUM_W];
    assign data_arr[gi]     = ch_tx_data[gi*DATA_W +: DATA_W];
    assign ch_tx_req[gi]    = (state_reg == BUSY) && tx_req && (grant_reg == CH_W'(gi));
    assign ch_tx_done[gi]   = done_now && (grant_reg == CH_W'(gi));
  end

  // A start on an already-busy channel is a no-op; completion clears the channel.
  assign pending_next = (pending_reg | ch_start_en) & ~ch_tx_done;

  assign ch_busy     = pending_reg;
  assign tx_byte_num = byte_num_reg;
  assign grant_id    = grant_reg;
  assign tx_data     = (state_reg == BUSY) ? data_arr[grant_reg] : data_arr[0];

`ifdef UDP_TX_TIMEOUT_EN
  logic [15:0] to_cnt_reg;
  logic        timeout_flag_reg;

  assign timeout_hit  = (state_reg == BUSY) && !tx_done &&
                        (to_cnt_reg == 16'(TIMEOUT_CYCLES - 1));
  assign timeout_flag = timeout_flag_reg;

  // Count cycles spent in BUSY; the error flag sticks until reset.
  always_ff @(posedge eth_tx_clk or posedge rst) begin
    if (rst) begin
      to_cnt_reg       <= '0;
      timeout_flag_reg <= 1'b0;
    end else begin
      to_cnt_reg <= (state_reg == BUSY) ? to_cnt_reg + 16'd1 : 16'd0;
      if (timeout_hit) begin
        timeout_flag_reg <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit  = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // Scheduler state and per-grant registers.
  always_ff @(posedge eth_tx_clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      pending_reg    <= '0;
      grant_reg      <= '0;
      last_grant_reg <= LAST_GRANT_RST;
      byte_num_reg   <= '0;
      done_pulse_reg <= 1'b0;
      gap_cnt_reg    <= '0;
    end else begin
      state_reg      <= state_next;
      pending_reg    <= pending_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
      byte_num_reg   <= byte_num_next;
      done_pulse_reg <= done_pulse_next;
      gap_cnt_reg    <= gap_cnt_next;
    end
  end

  // Next-state logic: grant in IDLE, kick the engine in START, wait in BUSY, hold off in GAP.
  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    byte_num_next   = byte_num_reg;
    done_pulse_next = 1'b0;
    gap_cnt_next    = gap_cnt_reg;
    tx_start_en     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          grant_next    = pick_index;
          byte_num_next = byte_num_arr[pick_index];
          state_next    = START;
        end
      end
      START: begin
        if (byte_num_reg == '0) begin
          last_grant_next = grant_reg;
          gap_cnt_next    = '0;
          state_next      = GAP;
        end else begin
          tx_start_en = 1'b1;
          state_next  = BUSY;
        end
      end
      BUSY: begin
        if (tx_done || timeout_hit) begin
          done_pulse_next = 1'b1;
          last_grant_next = grant_reg;
          gap_cnt_next    = '0;
          state_next      = GAP;
        end
      end
      GAP: begin
        if (int'(gap_cnt_reg) >= GAP_CYCLES - 1) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt_reg + 16'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_udp_tx_sched.sv
// Randomized self-checking bench for udp_tx_sched. A transaction-level
// reference model predicts grants, timing, routing and completions from
// the scheduling rules; every cycle the DUT outputs are compared to it.
module tb_udp_tx_sched;
  import udp_tx_sched_pkg::*;

  localparam int NUM_CH         = 2;
  localparam int GAP_CYCLES     = 12;
  localparam int TIMEOUT_CYCLES = 100;
  localparam int CW             = ch_w(NUM_CH);
  localparam int GAP_W          = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
`ifdef UDP_TX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NUM_CH-1:0]        ch_start_en = '0;
  logic [NUM_CH*16-1:0]     ch_byte_num = '0;
  logic [NUM_CH*32-1:0]     ch_tx_data = '0;
  logic [NUM_CH-1:0]        ch_tx_req, ch_tx_done, ch_busy;
  logic                     tx_start_en;
  logic [15:0]              tx_byte_num;
  logic [31:0]              tx_data;
  logic                     tx_req = 1'b0;
  logic                     tx_done = 1'b0;
  logic [CW-1:0]            grant_id;
  logic                     timeout_flag;

  always #5 clk = ~clk;

  udp_tx_sched #(
    .NUM_CH         (NUM_CH),
    .GAP_CYCLES     (GAP_CYCLES),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .eth_tx_clk   (clk),
    .rst          (rst),
    .ch_start_en  (ch_start_en),
    .ch_byte_num  (ch_byte_num),
    .ch_tx_data   (ch_tx_data),
    .ch_tx_req    (ch_tx_req),
    .ch_tx_done   (ch_tx_done),
    .ch_busy      (ch_busy),
    .tx_start_en  (tx_start_en),
    .tx_byte_num  (tx_byte_num),
    .tx_data      (tx_data),
    .tx_req       (tx_req),
    .tx_done      (tx_done),
    .grant_id     (grant_id),
    .timeout_flag (timeout_flag)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_pkts = 0;

  // Reference model state.
  bit          pend    [NUM_CH];
  int          set_cyc [NUM_CH];
  logic [15:0] m_bytes [NUM_CH];
  logic [31:0] m_data  [NUM_CH];
  int          last_g, own, busy_n, pkt_len, free_cyc, done_ch;
  bit          own_busy, done_due, m_to;
  logic [CW-1:0] m_grant;
  logic [15:0]   m_len;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Next channel by round robin among requests visible to the scheduler.
  function automatic int pick_next();
    for (int k = 1; k <= NUM_CH; k++) begin
      int c;
      c = (last_g + k) % NUM_CH;
      if (pend[c] && set_cyc[c] <= cyc - 2) return c;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      pend[i]    = 1'b0;
      set_cyc[i] = 0;
      m_bytes[i] = '0;
    end
    last_g   = NUM_CH - 1;
    own      = -1;
    own_busy = 1'b0;
    busy_n   = 0;
    pkt_len  = 0;
    free_cyc = 0;
    done_due = 1'b0;
    done_ch  = 0;
    m_to     = 1'b0;
    m_grant  = '0;
    m_len    = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ch_tx_req"}, 32'(ch_tx_req), 32'd0);
    check_eq({tag, "_ch_tx_done"}, 32'(ch_tx_done), 32'd0);
    check_eq({tag, "_ch_busy"}, 32'(ch_busy), 32'd0);
    check_eq({tag, "_tx_start_en"}, 32'(tx_start_en), 32'd0);
    check_eq({tag, "_tx_byte_num"}, 32'(tx_byte_num), 32'd0);
    check_eq({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    check_eq({tag, "_timeout_flag"}, 32'(timeout_flag), 32'd0);
    check_eq({tag, "_tx_data"}, tx_data, ch_tx_data[31:0]);
  endtask

  // One clock cycle: drive inputs after the falling edge, check, advance the model.
  task automatic step(input int p_start);
    logic [NUM_CH-1:0] accept, exp_done, exp_req, exp_busy;
    logic              exp_start;
    logic [31:0]       exp_data;
    int                p;
    @(negedge clk);
    cyc++;
    if (own_busy) begin
      busy_n++;
      tx_req  = 1'($urandom_range(0, 1));
      tx_done = (busy_n >= pkt_len);
    end else begin
      tx_req  = ($urandom_range(0, 3) == 0);
      tx_done = ($urandom_range(0, 15) == 0);
    end
    accept = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_start_en[i] = ($urandom_range(0, 99) < p_start);
      m_data[i] = $urandom;
      ch_tx_data[i*32 +: 32] = m_data[i];
      if (!pend[i]) begin
        ch_byte_num[i*16 +: 16] = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 1500));
        accept[i] = ch_start_en[i];
      end
    end
    #1;
    exp_done  = '0;
    exp_req   = '0;
    exp_start = 1'b0;
    for (int i = 0; i < NUM_CH; i++) exp_busy[i] = pend[i];
    if (done_due) exp_done[done_ch] = 1'b1;
    p = -1;
    if (own < 0 && cyc >= free_cyc) p = pick_next();
    if (p >= 0) begin
      m_grant = CW'(p);
      m_len   = m_bytes[p];
      n_pkts++;
      $display("pkt %0d: ch %0d len %0d granted at cycle %0d", n_pkts, p, m_len, cyc);
      if (m_len == 16'd0) exp_done[p] = 1'b1;
      else                exp_start   = 1'b1;
    end
    exp_data = own_busy ? m_data[own] : m_data[0];
    if (own_busy && tx_req) exp_req[own] = 1'b1;
    check_eq("ch_busy", 32'(ch_busy), 32'(exp_busy));
    check_eq("tx_start_en", 32'(tx_start_en), 32'(exp_start));
    check_eq("ch_tx_done", 32'(ch_tx_done), 32'(exp_done));
    check_eq("ch_tx_req", 32'(ch_tx_req), 32'(exp_req));
    check_eq("tx_data", tx_data, exp_data);
    check_eq("grant_id", 32'(grant_id), 32'(m_grant));
    check_eq("tx_byte_num", 32'(tx_byte_num), 32'(m_len));
    check_eq("timeout_flag", 32'(timeout_flag), 32'(m_to));
    // Advance the model to the next cycle.
    if (done_due) begin
      pend[done_ch] = 1'b0;
      done_due      = 1'b0;
    end
    if (own_busy && (tx_done || (TO_EN && busy_n == TIMEOUT_CYCLES))) begin
      if (!tx_done) m_to = 1'b1;
      done_due = 1'b1;
      done_ch  = own;
      last_g   = own;
      free_cyc = cyc + GAP_W + 2;
      own      = -1;
      own_busy = 1'b0;
    end
    if (p >= 0) begin
      if (m_len == 16'd0) begin
        pend[p]  = 1'b0;
        last_g   = p;
        free_cyc = cyc + GAP_W + 2;
      end else begin
        own      = p;
        own_busy = 1'b1;
        busy_n   = 0;
        pkt_len  = (TO_EN && ($urandom_range(0, 3) == 0)) ? 1000 : int'($urandom_range(1, 12));
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept[i]) begin
        pend[i]    = 1'b1;
        set_cyc[i] = cyc;
        m_bytes[i] = ch_byte_num[i*16 +: 16];
      end
    end
  endtask

  initial begin
    int n;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst = 1'b0;

    repeat (400) step(30);
    repeat (300) step(100);   // every channel re-requests as soon as it is free
    repeat (200) step(5);

    // Reset in the middle of a packet.
    n = 0;
    while (!(own_busy && busy_n >= 1) && n < 2000) begin
      step(50);
      n++;
    end
    check_eq("busy_wait_bound", 32'(n < 2000), 32'd1);
    #2;
    tx_req = 1'b1;
    rst    = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    ch_start_en = '0;
    rst = 1'b0;
    model_reset();

    repeat (2) step(100);     // simultaneous starts right after reset: channel 0 first
    repeat (400) step(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/udp_tx_sched.md
Name: udp_tx_sched

Overview:
- Round-robin scheduler that shares the single UDP transmit engine between NUM_CH packet sources, e.g. the loopback echo path and an audio status/request source.
- Latches per-channel start pulses and grants the engine to one channel at a time.
- Drives the engine's start/length inputs, routes its data requests and data back to the granted channel, and returns the completion pulse to it.
- Sits in the eth_tx_clk domain between the channel FIFOs and the udp block; channel start pulses must already be synchronised into eth_tx_clk.

Parameters:
- NUM_CH, 2: number of requesting channels (2..8).
- GAP_CYCLES, 12: idle cycles enforced after each packet completes, before the next grant.
- TIMEOUT_CYCLES, 65535: maximum BUSY duration. Used only when UDP_TX_TIMEOUT_EN is defined.

Ports:
- eth_tx_clk  in  1  only clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- ch_start_en  in  NUM_CH  one-cycle start pulse per channel.
- ch_byte_num  in  NUM_CH*16  payload bytes for each channel; channel i occupies bits [16i+15:16i].
- ch_tx_data  in  NUM_CH*32  data word for each channel; channel i occupies bits [32i+31:32i].
- ch_tx_req  out  NUM_CH  data request to the channel, asserted only toward the granted channel.
- ch_tx_done  out  NUM_CH  one-cycle completion pulse to the channel.
- ch_busy  out  NUM_CH  channel is pending or active.
- tx_start_en  out  1  start pulse to the UDP engine.
- tx_byte_num  out  16  length for the granted packet.
- tx_data  out  32  data from the granted channel.
- tx_req  in  1  data request from the UDP engine.
- tx_done  in  1  packet-sent pulse from the UDP engine.
- grant_id  out  clog2(NUM_CH)  index of the currently granted channel.
- timeout_flag  out  1  sticky timeout error flag.

Behaviour:
- Reset values: all outputs 0. pending=0, state=IDLE, last_grant=NUM_CH-1, so channel 0 wins first.
- pending[i]:
  - Set on ch_start_en[i] when ch_busy[i]=0.
  - A start while ch_busy[i]=1 is dropped, with no queueing.
  - Cleared in the cycle ch_tx_done[i] pulses.
  - ch_busy equals pending.
- FSM states: IDLE, START, BUSY, GAP.
- IDLE:
  - If pending is nonzero, select the first pending channel searching last_grant+1 upward, with modulo wrap.
  - Register grant_id and latch ch_byte_num into tx_byte_num.
  - Go to START.
- START:
  - If the latched byte_num is 0: no engine activity. Pulse ch_tx_done[grant], then go to GAP.
  - Otherwise assert tx_start_en for exactly 1 cycle and go to BUSY.
- BUSY:
  - ch_tx_req[grant_id] = tx_req (combinational).
  - tx_data = ch_tx_data of grant_id (combinational mux).
  - On tx_done: pulse ch_tx_done[grant_id] in the next cycle, set last_grant=grant_id, go to GAP.
- GAP: count GAP_CYCLES cycles, then go to IDLE. With GAP_CYCLES=0, go to IDLE next cycle.
- Latency: ch_start_en sampled at edge k (channel idle, FSM in IDLE) gives tx_start_en high in the cycle after edge k+1.
- Simultaneous starts on several channels in one cycle: all are latched and served in round-robin order.
- Non-granted channels: ch_tx_req is always 0 outside BUSY and for every non-granted channel.
- tx_data: when no grant is active, tx_data = channel 0 data (don't-care).
- tx_req or tx_done outside BUSY: ignored.
- rst asserted mid-packet: immediate return to the reset state. No ch_tx_done is issued; the source must re-request.
- tx_byte_num and grant_id stay stable from IDLE exit until the next IDLE exit.

Optional Feature:
- Macro: UDP_TX_TIMEOUT_EN.
- When defined:
  - A 16-bit counter runs in BUSY.
  - If it reaches TIMEOUT_CYCLES with no tx_done, abort the packet: pulse ch_tx_done[grant], clear pending, set timeout_flag (sticky until rst), go to GAP.
- When undefined: no counter; timeout_flag is tied 0; BUSY waits indefinitely.

Decomposition:
- Package udp_tx_sched_pkg:
  - FSM state encoding (IDLE, START, BUSY, GAP as 2-bit localparams).
  - CH_W = clog2(NUM_CH) helper function.
  - BYTE_NUM_W=16, DATA_W=32.
- Sub-module rr_pick: combinational round-robin selector. Inputs: pending vector, last_grant. Outputs: valid, index. Instantiated once.

Test Plan:
- Single channel: ch_start_en[0] with byte_num=64 → tx_start_en is 2 cycles later and tx_byte_num=64; each tx_req is forwarded to ch_tx_req[0]; tx_done gives ch_tx_done[0] one cycle later; then 12 GAP cycles pass before any new grant.
- Both channels start in the same cycle (byte_num 16 and 32) → ch0 served first, then ch1; tx_byte_num 16 then 32; ch_tx_req[1] is 0 throughout ch0's packet.
- Fairness: keep both channels re-requesting immediately after each done, for 6 packets → grant_id sequence 0,1,0,1,0,1.
- ch_start_en[1] while ch_busy[1]=1 → dropped: exactly one packet for ch1; byte_num=0 request → ch_tx_done with no tx_start_en.
- rst pulse during BUSY → all outputs 0 within one cycle; next request is granted to ch0 normally.
- With UDP_TX_TIMEOUT_EN and TIMEOUT_CYCLES=100, withhold tx_done → abort at cycle 100 of BUSY: ch_tx_done pulses, timeout_flag=1; the next pending channel is still served.
